// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator between the execute stage and a
// word-organised data memory. Byte/half/word requests become word accesses;
// sub-word stores go through read-modify-write, loads are sign/zero extended.
module lsu_mem_master #(
    parameter int ADDR_W    = 10,
    parameter int MEM_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_A,
    output logic [31:0]       mem_WD,
    output logic              mem_WE,
    input  logic [31:0]       mem_RD
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t            state;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rd_q;
    logic              req_err;

    // Decide whether a request can be serviced: alignment, reserved size,
    // address bits beyond the memory port, and words past the implemented end.
    function automatic logic access_error(input logic [1:0]  size,
                                          input logic [31:0] addr);
        logic [31:0] idx_ext;
        logic        bad;
        idx_ext = {{(32-ADDR_W){1'b0}}, addr[ADDR_W+1:2]};
        bad = 1'b0;
        if (size == 2'b11)                        bad = 1'b1;
        if (size == SZ_HALF && addr[0])           bad = 1'b1;
        if (size == SZ_WORD && addr[1:0] != 2'b0) bad = 1'b1;
        if ((addr >> (ADDR_W + 2)) != 32'd0)      bad = 1'b1;
        if (idx_ext >= 32'(MEM_WORDS))            bad = 1'b1;
        return bad;
    endfunction

    // Replace the addressed lane of the old word with right-aligned store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                               input logic [31:0] wd,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] r;
        r = old_word;
        case (size)
            SZ_BYTE: r[{off, 3'b000} +: 8]        = wd[7:0];
            SZ_HALF: r[{off[1], 4'b0000} +: 16]   = wd[15:0];
            default: r                            = wd;
        endcase
        return r;
    endfunction

    // Pull the addressed lane out of a read word and extend it to 32 bits.
    function automatic logic [31:0] extract_ext(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic        uns,
                                                input logic [1:0]  off);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] sx;
        b  = word[{off, 3'b000} +: 8];
        h  = word[{off[1], 4'b0000} +: 16];
        sx = word;
        case (size)
            SZ_BYTE: sx = uns ? {24'd0, b} : 32'(b);
            SZ_HALF: sx = uns ? {16'd0, h} : 32'(h);
            default: sx = word;
        endcase
        return sx;
    endfunction

    assign req_err = access_error(req_size, req_addr);

    // Request/response state machine; latches the request on handshake and
    // captures the read word in RD. Reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rd_q    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        off_q   <= req_addr[1:0];
                        idx_q   <= req_addr[ADDR_W+1:2];
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        state   <= req_err ? RSP : RD;
                    end
                end
                RD: begin
                    rd_q  <= mem_RD;
                    state <= we_q ? WR : RSP;
                end
                WR:      state <= RSP;
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode from the current state; everything is forced low while
    // rst is high, which also suppresses a write that coincides with reset.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'd0;
        mem_A     = '0;
        mem_WD    = 32'd0;
        mem_WE    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: req_ready = 1'b1;
                RD:   mem_A     = idx_q;
                WR: begin
                    mem_A  = idx_q;
                    mem_WD = merge_lane(rd_q, wdata_q, size_q, off_q);
                    mem_WE = 1'b1;
                end
                default: begin
                    rsp_valid = 1'b1;
                    rsp_err   = err_q;
                    if (!we_q && !err_q)
                        rsp_rdata = extract_ext(rd_q, size_q, uns_q, off_q);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: behavioural word memory on the memory port, a
// reference memory image, and in-order scoreboards for responses and writes.
module tb_lsu_mem_master;

    localparam int ADDR_W = 10;
    localparam int NWORDS = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]        req_size;
    logic [31:0]       req_addr, req_wdata;
    logic              rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] mem_A;
    logic [31:0]       mem_WD, mem_RD;
    logic              mem_WE;

    lsu_mem_master #(.ADDR_W(ADDR_W), .MEM_WORDS(NWORDS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    // memory attached to the port and the bench's own image of it
    logic [31:0] mem [0:NWORDS-1];
    logic [31:0] ref_mem [0:NWORDS-1];
    assign mem_RD = (int'(mem_A) < NWORDS) ? mem[mem_A[4:0]] : 32'd0;
    always @(posedge clk) if (mem_WE) mem[mem_A[4:0]] <= mem_WD;

    typedef struct { logic [31:0] rdata; logic err; int lat; } rsp_t;
    typedef struct { logic [31:0] idx; logic [31:0] data; } wr_t;
    rsp_t exp_q[$];
    wr_t  wr_q[$];
    int   acc_q[$];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int n_issued = 0;
    int n_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
               (sz == 2'b10 && a[1:0] != 2'b00) || (a >= 32'h80);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                              input logic uns, input logic [1:0] off);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (w >> (off * 8)) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (w >> (off[1] * 16)) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] m;
        m = (sz == 2'b00) ? (32'hFF << (off * 8)) :
            (sz == 2'b01) ? (32'hFFFF << (off[1] * 16)) : 32'hFFFF_FFFF;
        return (old & ~m) | ((wd << ((sz == 2'b00) ? off * 8 : (sz == 2'b01) ? off[1] * 16 : 0)) & m);
    endfunction

    // response, write and handshake monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready) begin
                acc_q.push_back(cyc + 1);
                n_acc++;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    rsp_t e;
                    int   a;
                    e = exp_q.pop_front();
                    a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
                    check_val("rsp_rdata", rsp_rdata, e.rdata);
                    check_val("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    check_val("rsp_latency", 32'(cyc + 1 - a), 32'(e.lat));
                end
            end
            if (mem_WE) begin
                if (wr_q.size() == 0) begin
                    check_val("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check_val("mem_A_write", {22'd0, mem_A}, w.idx);
                    check_val("mem_WD", mem_WD, w.data);
                end
            end
            if (req_ready && (rsp_valid || mem_WE || mem_A != '0))
                check_val("ready_outside_idle", 32'd1, 32'd0);
        end
    end

    // Drive one request and hold it until the DUT takes it.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input bit track);
        rsp_t        e;
        wr_t         w;
        logic [31:0] idx;
        int          n;
        idx     = {27'd0, addr[6:2]};
        e.err   = model_err(sz, addr);
        e.rdata = 32'd0;
        e.lat   = e.err ? 1 : (we ? 3 : 2);
        if (track) begin
            if (!e.err && we) begin
                w.idx  = idx;
                w.data = model_store(ref_mem[idx[4:0]], wd, sz, addr[1:0]);
                ref_mem[idx[4:0]] = w.data;
                wr_q.push_back(w);
            end
            if (!e.err && !we) e.rdata = model_load(ref_mem[idx[4:0]], sz, uns, addr[1:0]);
            exp_q.push_back(e);
            n_issued++;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_val("handshake_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 30) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check_val("drain", 32'(exp_q.size() + wr_q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        for (int i = 0; i < NWORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_val("rst_outputs", {29'd0, rsp_valid, mem_WE, rsp_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("post_rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        check_val("post_rst_rdata", rsp_rdata, 32'd0);
        check_val("post_rst_memA", {22'd0, mem_A}, 32'd0);
        check_val("post_rst_memWD", mem_WD, 32'd0);
        check_val("post_rst_memWE", {31'd0, mem_WE}, 32'd0);
        @(posedge clk); #1;

        // word store / load
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
        drain();
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        drain();
        check_val("word_image", mem[4], 32'hDEADBEEF);

        // byte store and loads
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, 1'b1);
        drain();
        check_val("byte_image", mem[4], 32'hDEADA5EF);
        issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b1);
        drain();

        // half store/load, misaligned half
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1);
        issue(1'b1, 2'b01, 1'b0, 32'h13, 32'h00005555, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b1);
        drain();
        check_val("half_image", mem[4], 32'h1234A5EF);

        // boundaries
        issue(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 1'b1);
        @(negedge clk);
        check_val("memA_last_word", {22'd0, mem_A}, 32'd31);
        drain();
        issue(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b1);
        issue(1'b1, 2'b10, 1'b0, 32'h1000, 32'h11111111, 1'b1);
        issue(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b0, 32'h7E, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b1, 32'h7E, 32'h0, 1'b1);
        drain();

        // reset during the write cycle
        saved = mem[8];
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_in_wr_memWE", {31'd0, mem_WE}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        acc_q.delete();
        n_acc--;
        @(negedge clk);
        check_val("ready_after_rst", {31'd0, req_ready}, 32'd1);
        check_val("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
        repeat (3) @(posedge clk);
        check_val("word_kept", mem[8], saved);
        #1;

        // back-to-back queued requests
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        issue(1'b1, 2'b00, 1'b0, 32'h23, 32'h0000007F, 1'b1);
        issue(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b1);
        drain();

        // random mix
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = (i % 8 == 7) ? ($urandom_range(0, 255)) : {25'd0, 7'($urandom_range(0, 127))};
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, $urandom, 1'b1);
        end
        drain();
        for (int i = 0; i < NWORDS; i++) check_val("final_image", mem[i], ref_mem[i]);
        check_val("accept_count", 32'(n_acc), 32'(n_issued));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-organised data memory: fixed 1-cycle combinational read port (`mem_RD` valid in the same cycle as `mem_A`), 1-cycle synchronous write.
- Converts CPU-side byte-addressed byte/half/word requests into word accesses on the memory port.
- Sub-word stores use read-modify-write.
- Loads are sign- or zero-extended.
- Sits between the core's execute stage and the data memory.

Parameters:
- ADDR_W, 10, width of memory word address `mem_A`.
- MEM_WORDS, 32, number of implemented memory words; word indices >= MEM_WORDS are errors.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access rejected, valid with rsp_valid.
- mem_A  out  ADDR_W  memory word address.
- mem_WD  out  32  memory write data.
- mem_WE  out  1  memory write enable.
- mem_RD  in  32  memory read data, combinational from mem_A.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - rst high at an edge forces state IDLE and clears all latched request/response registers.
  - While rst is high, all outputs are 0, including req_ready.
  - After release: req_ready=1; rsp_valid, rsp_err, rsp_rdata, mem_A, mem_WD, mem_WE are 0.
- Little-endian lanes:
  - byte k = bits [8k+7:8k], k=addr[1:0].
  - half = bits [16h+15:16h], h=addr[1].
- Word index: idx = req_addr[ADDR_W+1:2].
- Error if any of:
  - size=11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - req_addr[31:ADDR_W+2] != 0.
  - idx >= MEM_WORDS.
- FSM states IDLE, RD, WR, RSP:
  - IDLE:
    - req_ready=1.
    - On handshake, latch we/size/unsigned/addr/wdata and the error flag.
    - Error -> RSP; else -> RD.
  - RD:
    - mem_A=idx, mem_WE=0.
    - Capture mem_RD into rd_q at the edge.
    - Load -> RSP; store -> WR.
  - WR:
    - mem_A=idx.
    - mem_WD = rd_q with the addressed lane replaced by wdata (word: wdata entirely).
    - mem_WE=1 for exactly this cycle.
    - -> RSP.
  - RSP:
    - rsp_valid=1 for exactly one cycle.
    - rsp_err=latched error flag.
    - rsp_rdata = extracted lane of rd_q, extended per size/unsigned (word: unchanged); 0 if store or error.
    - -> IDLE.
- Outputs outside their state:
  - req_ready=0 outside IDLE.
  - mem_WE=0 outside WR, and also in WR if rst is high (a reset during WR suppresses the write).
  - mem_A=0 in IDLE/RSP; mem_WD=0 outside WR.
- Response has no backpressure; a new request can be accepted in the cycle after rsp_valid.
- Latency from acceptance edge T:
  - load rsp_valid during cycle T+2.
  - store rsp_valid during T+3.
  - error rsp_valid during T+1.
- Errored requests never assert mem_WE.
- Reset mid-operation: the in-flight request is dropped with no response.

Test Plan:
1. Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_WE one cycle with mem_A=4, mem_WD=0xDEADBEEF; load rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid 2 cycles after load acceptance, 3 after store acceptance.
2. Byte store 0xA5 @0x11 over 0xDEADBEEF -> mem_WD=0xDEADA5EF. Byte load @0x11: signed -> 0xFFFFFFA5; unsigned -> 0x000000A5.
3. Half store 0x1234 @0x12 -> word 0x1234A5EF; signed half load @0x12 -> 0x00001234; half load @0x13 -> rsp_err=1, rsp_rdata=0, 1-cycle latency, mem_WE never high.
4. Word load @0x7C -> ok, mem_A=31. Word load @0x80 -> err (idx 32). Store @0x1000 -> err (upper bits set), no write. size=11 -> err.
5. Assert rst during the WR cycle of a store -> mem_WE low that cycle, memory word unchanged, no rsp_valid, req_ready=1 the cycle after rst drops.
6. req_valid held high with 3 queued requests (load, store, load) -> req_ready high only in IDLE, each request accepted exactly once, responses in order with latencies 2/3/2.
